// File: rtl/pipe_pkg.sv
// Shared fetch-stage definitions: next-PC select codes, reset/bubble defaults,
// FSM state encoding and the {npc, inst} payload carried into IF/ID.
package pipe_pkg;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
  localparam logic [1:0] PC_SEL_REG    = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] inst;
  } ifid_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipe_fetch_buf.sv
// One-entry skid buffer holding a fetched {npc, inst} while IF/ID is stalled.
// Updates on the next edge; flush beats push, push beats pop.
module pipe_fetch_buf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o,
  output logic        valid_o
);

  logic [63:0] data_q, data_d;
  logic        valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_fetch.sv
// Fetch stage: PC/redirect logic, imem request FSM and IF/ID register; ack reaches IF/ID one edge later.
// On an ID stall one in-flight word skids into the buffer and requests pause until the stall clears.
module pipe_fetch
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_stall,
  input  logic [1:0]  in_pc_sel,
  input  logic [31:0] in_pc_baddr,
  input  logic [31:0] in_pc_jaddr,
  input  logic [31:0] in_rs_data,
  output logic        out_imem_req,
  output logic [31:0] out_imem_addr,
  input  logic        in_imem_ack,
  input  logic [31:0] in_imem_rdata,
  output logic [31:0] out_npc,
  output logic [31:0] out_instruction,
  output logic        out_valid
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  npc_q;
  logic [31:0]  inst_q;
  logic         valid_q;
  logic         req_q;

  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         redirect;
  logic         buf_push;
  logic         buf_pop;
  logic         buf_vld;
  ifid_t        push_entry;
  ifid_t        buf_entry;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    case (in_pc_sel)
      PC_SEL_BRANCH: target = word_align(in_pc_baddr);
      PC_SEL_JUMP:   target = word_align(in_pc_jaddr);
      PC_SEL_REG:    target = word_align(in_rs_data);
      default:       target = pc_plus4;
    endcase
  end

  // Only a real instruction leaving IF/ID this cycle can steer the PC.
  assign redirect = valid_q && !in_stall && (in_pc_sel != PC_SEL_SEQ);

  assign push_entry = '{npc: pc_plus4, inst: in_imem_rdata};
  assign buf_push   = (state_q == ST_REQ) && in_imem_ack && in_stall;
  assign buf_pop    = (state_q == ST_HOLD) && !in_stall && !redirect;

  pipe_fetch_buf u_buf (
    .clk_i   (in_clk),
    .rst_ni  (in_rst),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .flush_i (redirect),
    .data_i  (push_entry),
    .data_o  (buf_entry),
    .valid_o (buf_vld)
  );

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      npc_q   <= 32'h0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_REQ;
          req_q   <= 1'b1;
        end
        ST_REQ: begin
          if (redirect) begin
            // Any ack landing this cycle belongs to the wrong path and is dropped.
            pc_q    <= target;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
          end else if (in_imem_ack) begin
            pc_q <= pc_plus4;
            if (in_stall) begin
              state_q <= ST_HOLD;
              req_q   <= 1'b0;
            end else begin
              npc_q   <= pc_plus4;
              inst_q  <= in_imem_rdata;
              valid_q <= 1'b1;
            end
          end else if (!in_stall) begin
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!in_stall) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            if (redirect) begin
              pc_q    <= target;
              inst_q  <= NOP_INST;
              valid_q <= 1'b0;
            end else begin
              npc_q   <= buf_entry.npc;
              inst_q  <= buf_entry.inst;
              valid_q <= buf_vld;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign out_imem_req    = req_q;
  assign out_imem_addr   = pc_q;
  assign out_npc         = npc_q;
  assign out_instruction = inst_q;
  assign out_valid       = valid_q;

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch: bench-side memory, expected-PC model and IF/ID scoreboard.
module tb_pipe_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        in_clk;
  logic        in_rst;
  logic        in_stall;
  logic [1:0]  in_pc_sel;
  logic [31:0] in_pc_baddr;
  logic [31:0] in_pc_jaddr;
  logic [31:0] in_rs_data;
  logic        out_imem_req;
  logic [31:0] out_imem_addr;
  logic        in_imem_ack;
  logic [31:0] in_imem_rdata;
  logic [31:0] out_npc;
  logic [31:0] out_instruction;
  logic        out_valid;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] mem_last;
  int          mem_cnt;
  int          mem_lat;
  logic        mem_en;
  int          found;

  pipe_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (NOP)
  ) dut (
    .in_clk          (in_clk),
    .in_rst          (in_rst),
    .in_stall        (in_stall),
    .in_pc_sel       (in_pc_sel),
    .in_pc_baddr     (in_pc_baddr),
    .in_pc_jaddr     (in_pc_jaddr),
    .in_rs_data      (in_rs_data),
    .out_imem_req    (out_imem_req),
    .out_imem_addr   (out_imem_addr),
    .in_imem_ack     (in_imem_ack),
    .in_imem_rdata   (in_imem_rdata),
    .out_npc         (out_npc),
    .out_instruction (out_instruction),
    .out_valid       (out_valid)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // Acts as ID (stall/redirect) and as instruction memory for the coming cycle.
  task automatic drive(input logic stall, input logic [1:0] sel, input logic [31:0] tgt);
    in_stall    = stall;
    in_pc_sel   = sel;
    in_pc_baddr = 32'h0BAD_0A00;
    in_pc_jaddr = 32'h0BAD_0B00;
    in_rs_data  = 32'h0BAD_0C00;
    case (sel)
      2'b01:   in_pc_baddr = tgt;
      2'b10:   in_pc_jaddr = tgt;
      2'b11:   in_rs_data  = tgt;
      default: ;
    endcase
    in_imem_ack   = 1'b0;
    in_imem_rdata = 32'hDEAD_BEEF;
    if (out_imem_req === 1'b1) begin
      chk("imem_addr", out_imem_addr, model_pc);
      if (out_imem_addr !== mem_last) begin
        mem_last = out_imem_addr;
        mem_cnt  = 0;
      end
      if (mem_en && mem_cnt >= mem_lat) begin
        in_imem_ack   = 1'b1;
        in_imem_rdata = ~out_imem_addr;
        mem_cnt       = 0;
        if (sel == 2'b00) begin
          exp_q.push_back({model_pc + 32'd4, ~model_pc});
          model_pc = model_pc + 32'd4;
        end
      end else begin
        mem_cnt++;
      end
    end
    if (sel != 2'b00) model_pc = {tgt[31:2], 2'b00};
  endtask

  task automatic wait_npc(input logic [31:0] npc, input string tag);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (out_valid === 1'b1 && out_npc === npc) found = 1;
      else drive(1'b0, 2'b00, 32'h0);
    end
    chk(tag, found, 1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"},   32'(out_imem_req), 0);
    chk({tag, "_addr"},  out_imem_addr, 32'h0);
    chk({tag, "_npc"},   out_npc, 32'h0);
    chk({tag, "_inst"},  out_instruction, NOP);
    chk({tag, "_valid"}, 32'(out_valid), 0);
  endtask

  // Every cycle ID takes a valid word, it must be the next expected one.
  task automatic monitor();
    forever begin
      @(negedge in_clk);
      if (in_rst === 1'b1 && out_valid === 1'b1 && in_stall === 1'b0) begin
        if (exp_q.size() == 0) chk("sb_unexpected_word", 32'(exp_q.size()), 1);
        else chk64("sb_word", {out_npc, out_instruction}, exp_q.pop_front());
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    in_rst        = 1'b0;
    in_stall      = 1'b0;
    in_pc_sel     = 2'b00;
    in_pc_baddr   = 32'h0;
    in_pc_jaddr   = 32'h0;
    in_rs_data    = 32'h0;
    in_imem_ack   = 1'b1;
    in_imem_rdata = 32'hBAAD_F00D;
    mem_en        = 1'b1;
    mem_lat       = 0;
    mem_cnt       = 0;
    mem_last      = 32'hFFFF_FFFF;
    model_pc      = 32'h0;

    tick();
    tick();
    check_reset("por");

    in_rst      = 1'b1;
    in_imem_ack = 1'b0;
    tick();
    chk("first_req", 32'(out_imem_req), 1);
    chk("first_addr", out_imem_addr, 32'h0);
    drive(1'b0, 2'b00, 32'h0);
    for (int i = 1; i <= 2; i++) begin
      tick();
      chk("stream_npc", out_npc, 32'(4 * i));
      chk("stream_inst", out_instruction, ~32'(4 * (i - 1)));
      drive(1'b0, 2'b00, 32'h0);
    end

    // Three stalled cycles: word @0xC skids into the buffer, requests pause.
    tick();
    chk("pre_stall_npc", out_npc, 32'hC);
    drive(1'b1, 2'b00, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_no_req", 32'(out_imem_req), 0);
      chk("stall_npc", out_npc, 32'hC);
      chk("stall_inst", out_instruction, ~32'h8);
      chk("stall_valid", 32'(out_valid), 1);
      drive((i < 2) ? 1'b1 : 1'b0, 2'b00, 32'h0);
    end
    tick();
    chk("unstall_npc", out_npc, 32'h10);
    chk("unstall_inst", out_instruction, ~32'hC);
    chk("unstall_req", 32'(out_imem_req), 1);
    drive(1'b0, 2'b00, 32'h0);

    // Branch to 0x40; the ack arriving with the redirect is dropped.
    wait_npc(32'h14, "reach_0x10");
    drive(1'b0, 2'b01, 32'h40);
    tick();
    chk("br_bubble_valid", 32'(out_valid), 0);
    chk("br_bubble_inst", out_instruction, NOP);
    chk("br_addr", out_imem_addr, 32'h40);
    drive(1'b0, 2'b00, 32'h0);
    tick();
    chk("br_npc", out_npc, 32'h44);
    chk("br_inst", out_instruction, ~32'h40);

    // Jump to the top word; PC+4 wraps to zero.
    drive(1'b0, 2'b10, 32'hFFFF_FFFE);
    tick();
    chk("wrap_addr", out_imem_addr, 32'hFFFF_FFFC);
    chk("wrap_bubble", 32'(out_valid), 0);
    drive(1'b0, 2'b00, 32'h0);
    tick();
    chk("wrap_npc", out_npc, 32'h0);
    chk("wrap_next_addr", out_imem_addr, 32'h0);

    // Slow memory: IF/ID drains between acks, then redirect while a request is outstanding.
    mem_lat = 3;
    drive(1'b0, 2'b00, 32'h0);
    tick();
    chk("drain_bubble", 32'(out_valid), 0);
    drive(1'b0, 2'b00, 32'h0);
    wait_npc(32'h4, "slow_0x0");
    drive(1'b0, 2'b11, 32'h103);
    tick();
    chk("jr_addr", out_imem_addr, 32'h100);
    chk("jr_bubble", 32'(out_valid), 0);
    drive(1'b0, 2'b00, 32'h0);
    wait_npc(32'h104, "slow_0x100");
    chk("jr_inst", out_instruction, ~32'h100);

    // Reset in the middle of the outstanding request to 0x104, with ack held high.
    drive(1'b0, 2'b00, 32'h0);
    #2;
    in_rst        = 1'b0;
    in_imem_ack   = 1'b1;
    in_imem_rdata = 32'hBAAD_F00D;
    exp_q.delete();
    #1;
    check_reset("mid_rst");
    tick();
    tick();
    check_reset("held_rst");

    in_rst      = 1'b1;
    in_imem_ack = 1'b0;
    mem_lat     = 0;
    mem_cnt     = 0;
    mem_last    = 32'hFFFF_FFFF;
    model_pc    = 32'h0;
    tick();
    chk("rel_req", 32'(out_imem_req), 1);
    chk("rel_addr", out_imem_addr, 32'h0);
    drive(1'b0, 2'b00, 32'h0);
    tick();
    chk("rel_npc", out_npc, 32'h4);
    drive(1'b0, 2'b00, 32'h0);
    mem_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1'b0, 2'b00, 32'h0);
    end
    tick();
    chk("final_drained", 32'(out_valid), 0);
    chk("final_sb_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
